// File: rtl/uart_rx_apb_if.sv
// APB bus signal bundle shared by the UART peripherals.

interface apb_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );
endinterface

// File: rtl/uart_rx_apb.sv
// APB-slave 8N1 UART receiver: 2-flop synchroniser, receive FSM, small byte FIFO and
// sticky error flags, with a registered level interrupt.

package params_pkg;
  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
endpackage

module uart_rx_apb #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic  clk,
  input  logic  reset,
  apb_if.slave  apb,
  input  logic  rx,
  output logic  rx_irq
);
  import params_pkg::*;

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HalfM1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BitM1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   Full   = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StStop     = 3'd3;
  localparam logic [2:0] StWaitHigh = 3'd4;

  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic          rx_irq_q, rx_irq_d;

  logic push_req, frame_set, push_ok, pop, ovr_set, clr_wr;
  logic rx_valid, fifo_full, rx_busy, access;
  logic unused_pwdata;

  assign unused_pwdata = ^{apb.pwdata[31:3], apb.pwdata[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitM1) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitM1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = StIdle;
          end else begin
            frame_set = 1'b1;
            state_d   = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWaitHigh: begin
        // One frame error per break: wait here for the line to recover.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_valid  = (count_q != '0);
  assign fifo_full = (count_q == Full);
  assign rx_busy   = (state_q != StIdle);
  assign access    = apb.psel & apb.penable;
  assign pop       = access & ~apb.pwrite & (apb.paddr == REG_DATA) & rx_valid;
  assign clr_wr    = access & apb.pwrite & (apb.paddr == REG_STATUS);
  assign push_ok   = push_req & (~fifo_full | pop);
  assign ovr_set   = push_req & fifo_full & ~pop;

  always_comb begin
    wptr_d = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // Set beats a simultaneous write-1-to-clear.
    overrun_d   = ovr_set | (overrun_q & ~(clr_wr & apb.pwdata[1]));
    frame_err_d = frame_set | (frame_err_q & ~(clr_wr & apb.pwdata[2]));
    rx_irq_d    = rx_valid | overrun_q | frame_err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_irq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_irq_q    <= rx_irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= shift_q;
  end

  always_comb begin
    case (apb.paddr)
      REG_DATA:   apb.prdata = {24'h0, rx_valid ? mem_q[rptr_q] : 8'h00};
      REG_STATUS: apb.prdata = {27'h0, rx_busy, fifo_full, frame_err_q, overrun_q, rx_valid};
      default:    apb.prdata = 32'h0;
    endcase
  end

  assign apb.pready = 1'b1;
  assign rx_irq     = rx_irq_q;

endmodule

// File: doc/uart_rx_apb.md
Name: uart_rx_apb

Overview:
APB-slave UART receiver, the receive-side peer of the APB UART TX peripheral on the same peripheral bus. Deserialises an asynchronous 8N1 serial line into bytes and buffers them in a small FIFO. Software reads the bytes and the sticky error/status flags through APB. Zero-wait-state slave that also drives a level interrupt to the SoC interrupt logic.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 4
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
apb  modport  apb_if.slave  APB slave; uses psel, penable, pwrite, paddr, pwdata[31:0], prdata[31:0], pready
rx  input  1  serial line in, idle high, asynchronous to clk
rx_irq  output  1  high while FIFO non-empty or any sticky error set

Behaviour:
- Reset (asynchronous, active-high) clears:
  - FSM to IDLE, FIFO empty, sticky flags 0, bit/clock counters 0
  - synchroniser flops set to 1
  - rx_irq=0, prdata=0
- Synchroniser: rx passes through 2 flops giving rx_s; all sampling uses rx_s.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START; clock counter cleared.
  - START: at count CLKS_PER_BIT/2-1 (integer divide), sample rx_s. 0 -> DATA, counter cleared, bit index 0. 1 -> IDLE (glitch rejected, no flag).
  - DATA: every CLKS_PER_BIT cycles sample rx_s into shift[bit_idx], LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s.
    - 1: push byte -> IDLE.
    - 0: set frame_err, discard byte -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1 -> IDLE. A held-low line (break) produces exactly one frame_err.
- FIFO push and overrun:
  - Push occurs in the cycle the stop bit is sampled high.
  - If the FIFO is full and no pop occurs that cycle: byte dropped, overrun set; FIFO contents unchanged.
  - Pop and push in the same cycle while full: both happen, no overrun.
  - Pointers wrap modulo FIFO_DEPTH; count occupies log2(FIFO_DEPTH)+1 bits.
- APB protocol:
  - pready tied 1; every access completes in its access phase (psel & penable).
  - prdata is combinational from paddr.
- APB registers (addresses REG_DATA / REG_STATUS from params_pkg):
  - REG_DATA read: prdata[7:0] = FIFO head (0 if empty), upper bits 0. Access-phase read (psel & penable & !pwrite) pops one entry if non-empty. A read while empty has no effect. Writes are ignored.
  - REG_STATUS read:
    - bit0 rx_valid (FIFO non-empty)
    - bit1 overrun (sticky)
    - bit2 frame_err (sticky)
    - bit3 fifo_full
    - bit4 rx_busy (FSM not IDLE)
    - others 0
  - REG_STATUS write: write-1-to-clear; pwdata[1] clears overrun, pwdata[2] clears frame_err. Other bits ignored. If a set and a clear hit the same cycle, the set wins.
  - Any other address: read 0, write ignored, no side effects.
- rx_irq is registered: rx_irq <= rx_valid | overrun | frame_err. It is 1 cycle delayed from the status bits.
- Latency: a byte becomes readable ≈ 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the rx falling edge.
- Reset asserted mid-frame: the partial byte is lost. After release the FSM waits in IDLE for the next low on rx_s.

Test Plan:
- Reset and idle: CLKS_PER_BIT=16, assert reset mid-simulation with rx=1 -> STATUS reads 0x00, rx_irq=0, REG_DATA reads 0x00.
- Single byte: drive 0xA5 (8N1, 16 clk/bit) -> STATUS=0x01 and rx_irq=1. REG_DATA read returns 0xA5, then STATUS=0x00 and rx_irq deasserts 1 cycle later.
- Overrun: send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads, FIFO_DEPTH=4 -> STATUS=0x0B. Reads return 0x11, 0x22, 0x33, 0x44, then 0x00. Write STATUS 0x02 -> STATUS=0x00.
- Framing/break: send 0x3C with stop bit 0, then hold rx low 40 bit times -> frame_err=1, FIFO empty, exactly one error. Release rx, send 0x7E -> received 0x7E, STATUS=0x05.
- Glitch rejection: rx low pulse of 3 clk -> FSM returns to IDLE, STATUS stays 0x00, no byte pushed.
- Pop/push collision and reset mid-frame:
  - FIFO full, REG_DATA read timed to the stop-sample cycle of 0x99 -> no overrun; 0x99 is the last entry.
  - Assert reset at data bit 4, then send 0x5A -> only 0x5A received.
